mmio_bridge: RTL
================

Name: mmio_bridge

Overview:
- Data-side bridge directly downstream of the single-cycle CPU core.
- Consumes the core's ALU address, store data and memory-write strobe, and returns load data to the core.
- Routes each access either to the data memory or to a small set of on-chip memory-mapped peripherals:
  - LED output register
  - 8-entry byte transmit FIFO with a valid/ready drain port
  - free-running timer with a compare interrupt
- Loads are combinational; all writes commit on the rising clock edge, matching the single-cycle core's timing.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- LED_W, 16, LED register width; at most 32.
- MMIO_BASE, 32'h0000_7F00, base of the peripheral window. Bits [7:0] must be zero.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_addr  in  32  byte address from the core ALU output
- cpu_wdata  in  32  store data from the core
- cpu_we  in  1  memory write strobe from the core
- cpu_rdata  out  32  load data to the core
- dm_addr  out  32  data memory address; always equals cpu_addr
- dm_wdata  out  32  data memory write data; always equals cpu_wdata
- dm_we  out  1  data memory write enable
- dm_rdata  in  32  data memory read data
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts the head byte
- led  out  LED_W  LED register
- irq  out  1  timer interrupt flag

Behaviour:
Address decode:
- sel_mmio = (cpu_addr[31:8] == MMIO_BASE[31:8]).
- dm_we = cpu_we & ~sel_mmio.
- cpu_rdata = sel_mmio ? mmio_rdata : dm_rdata, purely combinational.
- Offsets use cpu_addr[7:2]; cpu_addr[1:0] are ignored.

Register map (offset: name, access):
- 0x00 LED: R/W. A write loads cpu_wdata[LED_W-1:0]; a read returns the value zero-extended.
- 0x04 TXDATA: W pushes cpu_wdata[7:0]. R returns {29'b0, overflow, full, empty}.
- 0x08 COUNT: R returns the timer count. W clears the count to 0; the written value is ignored.
- 0x0C CMP: R/W compare value.
- 0x10 IRQSTAT: R returns {30'b0, overflow, irq}. W1C: bit0 clears irq, bit1 clears overflow.
- Other offsets: read 32'b0; writes have no effect.
- Reads never have side effects.

Reset (rst low, asynchronous):
- LED=0, FIFO empty (rd/wr pointers and count 0), overflow=0, COUNT=0, CMP=32'hFFFF_FFFF, irq=0.
- Consequences: tx_valid=0, tx_data=8'h00, led=0, irq=0.
- The FIFO contents array is not reset.
- Reset mid-drain discards all queued bytes.

TX FIFO:
- First-word-fall-through: tx_valid = (count != 0), tx_data = mem[rd_ptr].
- tx_data reads 8'h00 when empty.
- Pop when tx_valid & tx_ready.
- Push when cpu_we & sel_mmio & offset==0x04.
- Push accepted when count < FIFO_DEPTH, or when a pop happens in the same cycle (full case: count unchanged, pointers both advance).
- Push rejected otherwise: data dropped and overflow set (sticky).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Count is log2(FIFO_DEPTH)+1 bits.
- full = (count == FIFO_DEPTH); empty = (count == 0).
- tx_data must not change while tx_valid=1 and tx_ready=0.

Timer:
- COUNT increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
- A COUNT write takes priority: the next value is 0.
- irq is set on the edge where COUNT == CMP (the pre-increment value).
- If set and W1C-clear hit irq in the same cycle, set wins.
- Same rule for overflow: a rejected push and a W1C-clear in the same cycle leave overflow=1.

Optional Feature:
- Macro MMIO_TIMER_EN.
- Defined: timer, CMP and the irq behaviour exactly as above.
- Undefined:
  - no COUNT/CMP registers are synthesized;
  - offsets 0x08 and 0x0C read 0 and ignore writes;
  - irq is tied to 0 and IRQSTAT bit0 reads 0.
- The FIFO and LED are unaffected either way.

Decomposition:
- Package mmio_pkg:
  - register offset constants OFF_LED, OFF_TXDATA, OFF_COUNT, OFF_CMP, OFF_IRQSTAT
  - status bit positions
  - reset value CMP_RST
- One sub-module: tx_fifo, parameterised by depth and width.
  - Contains pointers, count, full/empty and the simultaneous push/pop rule.
  - Exposes push, push_data, pop, head, full, empty, push_rejected.
- Decode, the register file and the timer stay in mmio_bridge.

Test Plan:
1. Write 0x1234 to 0x0000_0040, then write 0xABCD to MMIO_BASE+0x00.
   - First write: dm_we=1 in its cycle. Second write: dm_we=0, and led=16'hABCD on the following cycle.
   - A read of MMIO_BASE+0x00 returns 0x0000ABCD.
2. With tx_ready=0, push bytes 0x41..0x48.
   - Status reads 0x2 (full).
   - A ninth push of 0x49 sets overflow, giving status 0x6.
   - Raise tx_ready for 8 cycles: bytes 0x41..0x48 drain in order, tx_valid falls, status reads 0x5.
3. With the FIFO full and tx_ready=1, push 0x55 in the same cycle as a pop.
   - Push accepted, count stays 8, overflow stays 0, and 0x55 emerges last.
4. Write CMP=10, then write COUNT.
   - irq rises on the edge where COUNT leaves 10.
   - Writing 1 to IRQSTAT clears it.
   - With MMIO_TIMER_EN undefined: offsets 0x08/0x0C read 0 and irq stays 0.
5. Assert rst low mid-drain with 3 bytes queued and LED=0xFFFF.
   - Immediately (no clock edge): tx_valid=0, led=0, irq=0.
   - After reset is released: status reads 0x1 and CMP reads 0xFFFFFFFF.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, status bit positions and reset constants shared
// by the mmio_bridge top level and its testbench.
package mmio_pkg;

  // Byte offsets of the peripheral registers inside the MMIO window
  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_TXDATA  = 8'h04;
  localparam logic [7:0] OFF_COUNT   = 8'h08;
  localparam logic [7:0] OFF_CMP     = 8'h0C;
  localparam logic [7:0] OFF_IRQSTAT = 8'h10;

  // TXDATA read-back status bits
  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;

  // IRQSTAT bits (read value and write-1-to-clear mask)
  localparam int IRQ_TMR_BIT = 0;
  localparam int IRQ_OVF_BIT = 1;

  // Compare register comes out of reset at the far end of the count range
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_LED,
    REG_TXDATA,
    REG_COUNT,
    REG_CMP,
    REG_IRQSTAT,
    REG_NONE
  } reg_sel_e;

  // Word-granular decode; the two byte-lane bits are ignored
  function automatic reg_sel_e decode_reg(input logic [7:0] off);
    reg_sel_e sel;
    sel = REG_NONE;
    case (off[7:2])
      OFF_LED[7:2]:     sel = REG_LED;
      OFF_TXDATA[7:2]:  sel = REG_TXDATA;
      OFF_COUNT[7:2]:   sel = REG_COUNT;
      OFF_CMP[7:2]:     sel = REG_CMP;
      OFF_IRQSTAT[7:2]: sel = REG_IRQSTAT;
      default:          sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_bridge_tx_fifo.sv
// tx_fifo: first-word-fall-through FIFO. A push into a full FIFO is still
// accepted when a pop happens in the same cycle; otherwise it is rejected
// and flagged on push_rejected. head reads zero while empty.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             push_rejected
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty         = (r_count == '0);
  assign full          = (r_count == CNT_FULL);
  assign w_pop_ok      = pop & ~empty;
  assign w_push_ok     = push & (~full | w_pop_ok);
  assign push_rejected = push & ~w_push_ok;
  assign head          = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; count only moves when push and pop differ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: data-side bridge behind the single-cycle core. Splits
// accesses between data memory and a peripheral window holding the LED
// register, a byte TX FIFO and an optional timer/compare interrupt.
// Build option: define MMIO_TIMER_EN to include COUNT/CMP and the timer irq.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          LED_W      = 16,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic             cpu_we,
  output logic [31:0]      cpu_rdata,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             dm_we,
  input  logic [31:0]      dm_rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  logic             w_sel_mmio;
  reg_sel_e         w_reg;
  logic             w_mmio_wr;
  logic             w_irqstat_wr;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_push_rej;
  logic [31:0]      w_count_val;
  logic [31:0]      w_cmp_val;
  logic             w_irq;
  logic [31:0]      w_mmio_rdata;
  logic [LED_W-1:0] r_led;
  logic             r_ovf;

  // Address decode and data-memory pass-through
  assign w_sel_mmio   = (cpu_addr[31:8] == MMIO_BASE[31:8]);
  assign w_reg        = decode_reg(cpu_addr[7:0]);
  assign w_mmio_wr    = cpu_we & w_sel_mmio;
  assign w_irqstat_wr = w_mmio_wr & (w_reg == REG_IRQSTAT);
  assign w_push       = w_mmio_wr & (w_reg == REG_TXDATA);

  assign dm_addr  = cpu_addr;
  assign dm_wdata = cpu_wdata;
  assign dm_we    = cpu_we & ~w_sel_mmio;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (w_push),
    .push_data     (cpu_wdata[7:0]),
    .pop           (tx_ready),
    .head          (tx_data),
    .full          (w_full),
    .empty         (w_empty),
    .push_rejected (w_push_rej)
  );

  assign tx_valid = ~w_empty;

  // LED register loads the low bits of a store to its offset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led <= '0;
    end else if (w_mmio_wr && (w_reg == REG_LED)) begin
      r_led <= cpu_wdata[LED_W-1:0];
    end
  end

  assign led = r_led;

  // Sticky overflow flag; a rejected push beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_push_rej) begin
      r_ovf <= 1'b1;
    end else if (w_irqstat_wr && cpu_wdata[IRQ_OVF_BIT]) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_irq;
  logic        w_count_wr;
  logic        w_cmp_wr;

  assign w_count_wr = w_mmio_wr & (w_reg == REG_COUNT);
  assign w_cmp_wr   = w_mmio_wr & (w_reg == REG_CMP);

  // Free-running counter; a store to COUNT restarts it from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_cmp   <= CMP_RST;
    end else begin
      r_count <= w_count_wr ? 32'd0 : r_count + 32'd1;
      if (w_cmp_wr) r_cmp <= cpu_wdata;
    end
  end

  // Compare match on the current count raises irq; set beats W1C clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq <= 1'b0;
    end else if (r_count == r_cmp) begin
      r_irq <= 1'b1;
    end else if (w_irqstat_wr && cpu_wdata[IRQ_TMR_BIT]) begin
      r_irq <= 1'b0;
    end
  end

  assign w_count_val = r_count;
  assign w_cmp_val   = r_cmp;
  assign w_irq       = r_irq;
`else
  assign w_count_val = 32'd0;
  assign w_cmp_val   = 32'd0;
  assign w_irq       = 1'b0;
`endif

  assign irq = w_irq;

  // Side-effect-free register read mux
  always_comb begin
    w_mmio_rdata = 32'd0;
    case (w_reg)
      REG_LED:     w_mmio_rdata = 32'(r_led);
      REG_TXDATA: begin
        w_mmio_rdata[ST_EMPTY_BIT] = w_empty;
        w_mmio_rdata[ST_FULL_BIT]  = w_full;
        w_mmio_rdata[ST_OVF_BIT]   = r_ovf;
      end
      REG_COUNT:   w_mmio_rdata = w_count_val;
      REG_CMP:     w_mmio_rdata = w_cmp_val;
      REG_IRQSTAT: begin
        w_mmio_rdata[IRQ_TMR_BIT] = w_irq;
        w_mmio_rdata[IRQ_OVF_BIT] = r_ovf;
      end
      default:     w_mmio_rdata = 32'd0;
    endcase
  end

  assign cpu_rdata = w_sel_mmio ? w_mmio_rdata : dm_rdata;

endmodule
